hdmux3_rr_sel: RTL

- Registered round-robin select generator for a 3:1 data mux cell (A0/A1/A2 inputs, SL0/SL1 selects, output Z).
- Arbitrates three requesters and drives glitch-free SL0/SL1 straight from flops.
- Holds each grant for a bounded burst of beats, then rotates priority.
- Sits directly upstream of the mux in the xsim std-cell datapath models.

---
 rtl/hdmux3_rr_sel.sv | 108 ++++++++++
 1 files changed

// File: rtl/hdmux3_rr_sel.sv
// Round-robin select generator for a 3:1 mux cell: registered SL0/SL1/GNT with
// bounded bursts of MAX_BEATS beats before priority rotates to the next input.
module hdmux3_rr_sel #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 8
) (
  input  logic       CK,
  input  logic       R,
  input  logic [2:0] REQ,
  input  logic       ADV,
  output logic       SL0,
  output logic       SL1,
  output logic [2:0] GNT,
  output logic       VLD,
  output logic       LAST
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0] cur;
  logic [1:0] nxt_ptr;
  logic [1:0] arb_ptr;
  logic [1:0] win;
  logic       any_req;
  logic       release_now;

  // First set request scanning upward from p, wrapping 2 -> 0.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] p);
    logic [1:0] o0, o1, o2;
    case (p)
      2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req[o0])      return o0;
    else if (req[o1]) return o1;
    else              return o2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // The select flops double as the record of the current winner.
  assign cur         = {SL1, SL0};
  assign any_req     = |REQ;
  assign release_now = (state == GRANT) &&
                       (((REQ & GNT) == 3'b000) || (ADV && (cnt == LAST_CNT)));
  assign nxt_ptr     = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
  assign arb_ptr     = release_now ? nxt_ptr : ptr;
  assign win         = pick(REQ, arb_ptr);
  assign LAST        = VLD && (cnt == LAST_CNT);

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      SL0   <= 1'b0;
      SL1   <= 1'b0;
      GNT   <= 3'b000;
      VLD   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= GRANT;
            GNT        <= onehot(win);
            {SL1, SL0} <= win;
            VLD        <= 1'b1;
            cnt        <= '0;
          end else begin
            GNT <= 3'b000;
            VLD <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= nxt_ptr;
            cnt <= '0;
            // Zero-bubble handover when anyone is still asking; selects hold otherwise.
            if (any_req) begin
              GNT        <= onehot(win);
              {SL1, SL0} <= win;
            end else begin
              state <= IDLE;
              GNT   <= 3'b000;
              VLD   <= 1'b0;
            end
          end else if (ADV) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
